sccb_arbmod: RTL and testbench

Two-requester arbiter in front of the single `sccb_funcmod` register-write engine. It lets the power-up configuration sequencer and a runtime tuner (exposure/gain updates) share one SCCB bus. It grants one requester at a time using round-robin, latches that requester's 16-bit `{reg_addr, reg_value}` word, and drives the engine's Call/Done handshake. A timeout recovers from an engine that never answers.

---
 rtl/camera_pkg.sv | 22 ++
 rtl/sccb_wdogmod.sv | 44 ++++
 rtl/sccb_arbmod.sv | 134 +++++++++++++
 tb/tb_sccb_arbmod.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
`default_nettype none
// ============================================================================
// camera_pkg : constants and types shared by the camera control blocks
// Rev 1.0
// ============================================================================
package camera_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int SCCB_DW          = 16;
    localparam int SCCB_TIMEOUT_DEF = 1_000_000;

    typedef logic [SCCB_DW-1:0] sccb_word_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_wdogmod.sv
`default_nettype none
// ============================================================================
// sccb_wdogmod : clear/enable watchdog counter, flags TIMEOUT-1 and saturates
// Rev 1.0
// ============================================================================
module sccb_wdogmod
    import camera_pkg::*;
#(
    parameter int TIMEOUT = SCCB_TIMEOUT_DEF
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sccb_arbmod.sv
`default_nettype none
// ============================================================================
// sccb_arbmod : round-robin arbiter sharing one sccb_funcmod between two users
// Rev 1.0
// ============================================================================
module sccb_arbmod
    import camera_pkg::*;
#(
    parameter int TIMEOUT = SCCB_TIMEOUT_DEF
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [1:0]         iCall,
    input  logic [SCCB_DW-1:0] iData0,
    input  logic [SCCB_DW-1:0] iData1,
    output logic [1:0]         oDone,
    output logic [1:0]         oErr,
    output logic [1:0]         oGrant,
    output logic               oBusy,
    output logic               oCall,
    output logic [SCCB_DW-1:0] oData,
    input  logic               iDone
);

    logic [1:0] state_q, state_d;
    logic [1:0] done_q, done_d;
    logic [1:0] err_q, err_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       call_q, call_d;
    logic       last_q, last_d;
    sccb_word_t data_q, data_d;

    logic gidx;
    logic pick;
    logic wdog_clr;
    logic wdog_en;
    logic expired;

    assign gidx     = grant_q[1];
    assign wdog_clr = (state_q == ST_IDLE);
    assign wdog_en  = (state_q == ST_WAIT);

    // On a tie the requester that was not served last wins
    assign pick = (iCall == 2'b11) ? ~last_q : iCall[1];

    sccb_wdogmod #(
        .TIMEOUT   (TIMEOUT)
    ) u_wdog (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .clr_i     (wdog_clr),
        .en_i      (wdog_en),
        .expired_o (expired)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            done_q  <= '0;
            err_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            call_q  <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            call_q  <= call_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (|iCall)            state_d = ST_WAIT;
            ST_WAIT:    if (iDone || expired)  state_d = ST_RELEASE;
            ST_RELEASE: if (!iCall[gidx])      state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        done_d  = '0;
        err_d   = '0;
        grant_d = grant_q;
        call_d  = call_q;
        data_d  = data_q;
        last_d  = last_q;
        busy_d  = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (|iCall) begin
                    grant_d = onehot2(pick);
                    data_d  = pick ? iData1 : iData0;
                    call_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (iDone || expired) begin
                    call_d = 1'b0;
                    done_d = grant_q;
                    err_d  = iDone ? 2'b00 : grant_q;
                    last_d = gidx;
                end
            end
            ST_RELEASE: begin
                // Grant is held until the served call drops, so a stale level is never re-served
                if (!iCall[gidx]) begin
                    grant_d = '0;
                end
            end
            default: begin
                grant_d = '0;
                call_d  = 1'b0;
            end
        endcase
    end

    assign oDone  = done_q;
    assign oErr   = err_q;
    assign oGrant = grant_q;
    assign oBusy  = busy_q;
    assign oCall  = call_q;
    assign oData  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_arbmod.sv
`default_nettype none
// ============================================================================
// tb_sccb_arbmod : randomized self-checking bench for sccb_arbmod
// Rev 1.0
// ============================================================================
module tb_sccb_arbmod;

    localparam int TMO = 100;

    logic        CLOCK;
    logic        RESET;
    logic [1:0]  iCall;
    logic [15:0] iData0;
    logic [15:0] iData1;
    logic        iDone;
    logic [1:0]  oDone;
    logic [1:0]  oErr;
    logic [1:0]  oGrant;
    logic        oBusy;
    logic        oCall;
    logic [15:0] oData;

    int checks;
    int errors;
    int m_last;

    sccb_arbmod #(.TIMEOUT(TMO)) dut (
        .CLOCK  (CLOCK),
        .RESET  (RESET),
        .iCall  (iCall),
        .iData0 (iData0),
        .iData1 (iData1),
        .oDone  (oDone),
        .oErr   (oErr),
        .oGrant (oGrant),
        .oBusy  (oBusy),
        .oCall  (oCall),
        .oData  (oData),
        .iDone  (iDone)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        iCall = 2'b00;
        iDone = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        m_last = 1;
    endtask

    task automatic test_reset();
        RESET  = 1'b0;
        iCall  = 2'b00;
        iDone  = 1'b0;
        iData0 = 16'h0000;
        iData1 = 16'h0000;
        #2;
        checks++;
        if ({oDone, oErr, oGrant, oBusy, oCall, oData} !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {oDone, oErr, oGrant, oBusy, oCall, oData});
        end
        tick();
        RESET = 1'b1;
        tick();
        m_last = 1;
    endtask

    task automatic test_single();
        do_reset();
        iData0 = 16'h1280;
        iCall  = 2'b01;
        tick();
        checks++;
        if ({oCall, oGrant, oData, oBusy} !== {1'b1, 2'b01, 16'h1280, 1'b1}) begin
            errors++;
            $display("FAIL single_grant: got call=%b grant=%b data=%h busy=%b want 1 01 1280 1",
                     oCall, oGrant, oData, oBusy);
        end
        repeat (49) tick();
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++;
        if ({oDone, oErr, oCall} !== {2'b01, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL single_done: got done=%b err=%b call=%b want 01 00 0", oDone, oErr, oCall);
        end
        iCall = 2'b00;
        tick();
        checks++;
        if ({oDone, oBusy, oGrant} !== 5'b0) begin
            errors++;
            $display("FAIL single_release: got done=%b busy=%b grant=%b want 00 0 00", oDone, oBusy, oGrant);
        end
        m_last = 0;
    endtask

    // Both requesters always pending: model picks the one not served last
    task automatic test_alternation();
        int g;
        int n;
        int lat;
        logic [15:0] want;
        do_reset();
        iData0 = 16'($urandom);
        iData1 = 16'($urandom);
        iCall  = 2'b11;
        for (int t = 0; t < 6; t++) begin
            n = 0;
            while (!oCall && n < 5) begin
                tick();
                n++;
            end
            g    = 1 - m_last;
            want = (g == 1) ? iData1 : iData0;
            checks++;
            if (oCall !== 1'b1 || oGrant !== 2'(1 << g) || oData !== want) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got call=%b grant=%b data=%h want 1 %b %h",
                         t, oCall, oGrant, oData, 2'(1 << g), want);
            end
            lat = $urandom_range(1, 20);
            repeat (lat - 1) tick();
            iDone = 1'b1;
            tick();
            iDone = 1'b0;
            checks++;
            if (oDone !== 2'(1 << g) || oErr !== 2'b00) begin
                errors++;
                $display("FAIL alt_done[%0d]: got done=%b err=%b want %b 00", t, oDone, oErr, 2'(1 << g));
            end
            m_last   = g;
            iCall[g] = 1'b0;
            iData0   = 16'($urandom);
            iData1   = 16'($urandom);
            tick();
            tick();
            iCall[g] = 1'b1;
        end
    endtask

    task automatic test_timeout();
        int k;
        do_reset();
        iData1 = 16'($urandom);
        iCall  = 2'b10;
        tick();
        checks++;
        if (oCall !== 1'b1 || oGrant !== 2'b10 || oData !== iData1) begin
            errors++;
            $display("FAIL tmo_grant: got call=%b grant=%b data=%h want 1 10 %h", oCall, oGrant, oData, iData1);
        end
        k = 0;
        while (oCall === 1'b1 && k < 3 * TMO) begin
            tick();
            k++;
        end
        checks++;
        if (k != TMO) begin
            errors++;
            $display("FAIL tmo_length: got %0d cycles want %0d", k, TMO);
        end
        checks++;
        if (oDone !== 2'b10 || oErr !== 2'b10) begin
            errors++;
            $display("FAIL tmo_pulse: got done=%b err=%b want 10 10", oDone, oErr);
        end
        iCall = 2'b00;
        tick();
        checks++;
        if (oDone !== 2'b00 || oErr !== 2'b00 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_after: got done=%b err=%b busy=%b want 00 00 0", oDone, oErr, oBusy);
        end
    endtask

    task automatic test_stale();
        int bad;
        do_reset();
        iData0 = 16'($urandom);
        iCall  = 2'b01;
        tick();
        repeat ($urandom_range(0, 9)) tick();
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++;
        if (oDone !== 2'b01) begin
            errors++;
            $display("FAIL stale_done: got %b want 01", oDone);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oBusy !== 1'b1 || oCall !== 1'b0 || oGrant !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stale_hold: got %0d bad cycles want 0", bad);
        end
        iCall  = 2'b10;
        iData1 = 16'($urandom);
        tick();
        checks++;
        if (oCall !== 1'b0 || oBusy !== 1'b0 || oGrant !== 2'b00) begin
            errors++;
            $display("FAIL stale_idle: got call=%b busy=%b grant=%b want 0 0 00", oCall, oBusy, oGrant);
        end
        tick();
        checks++;
        if (oCall !== 1'b1 || oGrant !== 2'b10 || oData !== iData1) begin
            errors++;
            $display("FAIL stale_next: got call=%b grant=%b data=%h want 1 10 %h", oCall, oGrant, oData, iData1);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        iData0 = 16'($urandom);
        iCall  = 2'b01;
        tick();
        repeat (10) tick();
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if ({oDone, oErr, oGrant, oBusy, oCall, oData} !== 24'h0) begin
            errors++;
            $display("FAIL midwait_reset: got %h want 0", {oDone, oErr, oGrant, oBusy, oCall, oData});
        end
        iCall  = 2'b10;
        iData1 = 16'($urandom);
        tick();
        RESET = 1'b1;
        tick();
        checks++;
        if (oCall !== 1'b1 || oGrant !== 2'b10 || oData !== iData1) begin
            errors++;
            $display("FAIL midwait_regrant: got call=%b grant=%b data=%h want 1 10 %h",
                     oCall, oGrant, oData, iData1);
        end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++;
        if (oDone !== 2'b10 || oErr !== 2'b00) begin
            errors++;
            $display("FAIL midwait_done: got done=%b err=%b want 10 00", oDone, oErr);
        end
        iCall = 2'b00;
        tick();
    endtask

    task automatic test_noise();
        logic [15:0] word;
        do_reset();
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        tick();
        checks++;
        if (oDone !== 2'b00 || oBusy !== 1'b0 || oCall !== 1'b0) begin
            errors++;
            $display("FAIL noise_idle_done: got done=%b busy=%b call=%b want 00 0 0", oDone, oBusy, oCall);
        end
        word   = 16'($urandom_range(0, 16'hFFFE));
        iData0 = word;
        iCall  = 2'b01;
        tick();
        iData0 = 16'hFFFF;
        repeat (5) tick();
        checks++;
        if (oData !== word || oCall !== 1'b1) begin
            errors++;
            $display("FAIL noise_data_hold: got data=%h call=%b want %h 1", oData, oCall, word);
        end
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        checks++;
        if (oDone !== 2'b01 || oData !== word) begin
            errors++;
            $display("FAIL noise_done: got done=%b data=%h want 01 %h", oDone, oData, word);
        end
        iCall = 2'b00;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_last = 1;
        test_reset();
        test_single();
        test_alternation();
        test_timeout();
        test_stale();
        test_reset_mid_wait();
        test_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
